// File: rtl/allocator_wavefront_locked_pkg.sv
// alloc_pkg: shared sizing helpers and row type for the wavefront allocator
package alloc_pkg;
  localparam int MAX_N = 32;
  typedef logic [MAX_N-1:0] alloc_req_t;
  function automatic int max_int(input int a, input int b);
    return a > b ? a : b;
  endfunction
  function automatic int ptr_width(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/allocator_wavefront_locked_if.sv
// allocator_wavefront_locked_if: request/lock inputs and grant/lock outputs of the allocator
interface allocator_wavefront_locked_if #(
  parameter int NUM_REQS = 4,
  parameter int NUM_RESS = 4
);
  logic [NUM_REQS-1:0][NUM_RESS-1:0] requests_i;
  logic [NUM_REQS-1:0]               lock_req_i;
  logic [NUM_REQS-1:0]               release_i;
  logic [NUM_REQS-1:0][NUM_RESS-1:0] grants_o;
  logic [NUM_REQS-1:0]               locked_o;
  modport slave (input requests_i, lock_req_i, release_i, output grants_o, locked_o);
  modport master (output requests_i, lock_req_i, release_i, input grants_o, locked_o);
endinterface

// File: rtl/allocator_wavefront_locked_core.sv
// wavefront_core: combinational N x N wavefront array starting at the priority diagonal
module wavefront_core #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0][N-1:0] req_i,
  input  logic [N-1:0]        row_free_i,
  input  logic [N-1:0]        col_free_i,
  input  logic [PW-1:0]       ptr_i,
  output logic [N-1:0][N-1:0] gnt_o
);
  logic [N-1:0]  row_free;
  logic [N-1:0]  col_free;
  logic [PW-1:0] j;
  // sweep diagonals from ptr; cells on one diagonal never share a row or column
  always_comb begin
    gnt_o    = '0;
    row_free = row_free_i;
    col_free = col_free_i;
    j        = '0;
    for (int d = 0; d < N; d++) begin
      for (int i = 0; i < N; i++) begin
        j = PW'((int'(ptr_i) + d + N - i) % N);
        if (req_i[i][j] && row_free[i] && col_free[j]) begin
          gnt_o[i][j] = 1'b1;
          row_free[i] = 1'b0;
          col_free[j] = 1'b0;
        end
      end
    end
  end
endmodule

// File: rtl/allocator_wavefront_locked.sv
// allocator_wavefront_locked: registered wavefront allocator with per-requester grant locking
module allocator_wavefront_locked
  import alloc_pkg::*;
#(
  parameter int NUM_REQS = 4,
  parameter int NUM_RESS = 4
) (
  input logic                     clk,
  input logic                     reset,
  allocator_wavefront_locked_if.slave bus
);
  localparam int N  = max_int(NUM_REQS, NUM_RESS);
  localparam int PW = ptr_width(N);

  logic [NUM_REQS-1:0][NUM_RESS-1:0] grants_q, grants_d;
  logic [NUM_REQS-1:0]               locked_q, locked_d;
  logic [PW-1:0]                     ptr_q, ptr_d;
  logic [NUM_RESS-1:0]               held_cols;
  logic [N-1:0][N-1:0]               req_pad, new_gnt;
  logic [N-1:0]                      row_free, col_free;

  // columns currently owned by a locked grant
  always_comb begin
    held_cols = '0;
    for (int i = 0; i < NUM_REQS; i++) held_cols = held_cols | (locked_q[i] ? grants_q[i] : '0);
  end

  // pad to a square array; padded rows/columns never request and are never free
  for (genvar r = 0; r < N; r++) begin : g_row
    if (r < NUM_REQS) begin : g_real
      assign row_free[r] = ~locked_q[r];
    end else begin : g_pad
      assign row_free[r] = 1'b0;
    end
    for (genvar c = 0; c < N; c++) begin : g_cell
      if (r < NUM_REQS && c < NUM_RESS) begin : g_real
        assign req_pad[r][c] = bus.requests_i[r][c];
      end else begin : g_pad
        assign req_pad[r][c] = 1'b0;
      end
    end
  end

  for (genvar c = 0; c < N; c++) begin : g_col
    if (c < NUM_RESS) begin : g_real
      assign col_free[c] = ~held_cols[c];
    end else begin : g_pad
      assign col_free[c] = 1'b0;
    end
  end

  wavefront_core #(.N(N), .PW(PW)) u_core (
    .req_i      (req_pad),
    .row_free_i (row_free),
    .col_free_i (col_free),
    .ptr_i      (ptr_q),
    .gnt_o      (new_gnt)
  );

  // locked rows hold until release; a released column stays masked for this edge
  always_comb begin
    grants_d = grants_q;
    locked_d = locked_q;
    for (int i = 0; i < NUM_REQS; i++) begin
      grants_d[i] = locked_q[i] ? (bus.release_i[i] ? '0 : grants_q[i]) : new_gnt[i][NUM_RESS-1:0];
      locked_d[i] = locked_q[i] ? ~bus.release_i[i] : (bus.lock_req_i[i] & (|new_gnt[i]));
    end
    ptr_d = (|new_gnt) ? (ptr_q == PW'(N - 1) ? '0 : ptr_q + 1'b1) : ptr_q;
  end

  // state registers, cleared asynchronously so a reset drops every lock at once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grants_q <= '0;
      locked_q <= '0;
      ptr_q    <= '0;
    end else begin
      grants_q <= grants_d;
      locked_q <= locked_d;
      ptr_q    <= ptr_d;
    end
  end

  assign bus.grants_o = grants_q;
  assign bus.locked_o = locked_q;

  for (genvar r = 0; r < NUM_REQS; r++) begin : g_chk_row
    a_row_onehot : assert property (@(posedge clk) disable iff (reset) $onehot0(grants_q[r]));
  end

  for (genvar c = 0; c < NUM_RESS; c++) begin : g_chk_col
    logic [NUM_REQS-1:0] col_bits;
    for (genvar r = 0; r < NUM_REQS; r++) begin : g_bit
      assign col_bits[r] = grants_q[r][c];
    end
    a_col_onehot : assert property (@(posedge clk) disable iff (reset) $onehot0(col_bits));
  end
endmodule

// File: tb/tb_allocator_wavefront_locked.sv
// tb_allocator_wavefront_locked: scoreboard bench for a 4x4 and a 3x5 allocator
module tb_allocator_wavefront_locked;
  import alloc_pkg::*;

  typedef struct packed {
    alloc_req_t [7:0] g;
    logic [7:0]       lk;
    logic [7:0]       ptr;
  } st_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  allocator_wavefront_locked_if #(.NUM_REQS(4), .NUM_RESS(4)) ifa ();
  allocator_wavefront_locked_if #(.NUM_REQS(3), .NUM_RESS(5)) ifb ();

  allocator_wavefront_locked #(.NUM_REQS(4), .NUM_RESS(4)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
  allocator_wavefront_locked #(.NUM_REQS(3), .NUM_RESS(5)) dut_b (.clk(clk), .reset(reset), .bus(ifb));

  int checks = 0;
  int errors = 0;
  st_t sa, sb, pa;
  st_t qa[$], qb[$];
  alloc_req_t [7:0] ra, rb;
  logic [7:0] la, rla, lb, rlb;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic st_t model(input st_t s, input int nq, input int ns,
                                input alloc_req_t [7:0] rq, input logic [7:0] lr, input logic [7:0] rl);
    int n, k;
    logic [7:0] rowb;
    alloc_req_t colb;
    alloc_req_t [7:0] ng;
    bit any;
    st_t o;
    n = max_int(nq, ns);
    rowb = s.lk;
    colb = '0;
    for (int i = 0; i < nq; i++) if (s.lk[i]) colb = colb | s.g[i];
    ng = '0;
    any = 0;
    for (int d = 0; d < n; d++) begin
      k = (int'(s.ptr) + d) % n;
      for (int i = 0; i < nq; i++)
        for (int j = 0; j < ns; j++)
          if ((i + j) % n == k && rq[i][j] && !rowb[i] && !colb[j]) begin
            ng[i][j] = 1'b1;
            rowb[i] = 1'b1;
            colb[j] = 1'b1;
            any = 1;
          end
    end
    o = s;
    for (int i = 0; i < nq; i++) begin
      if (s.lk[i]) begin
        if (rl[i]) begin
          o.g[i] = '0;
          o.lk[i] = 1'b0;
        end
      end else begin
        o.g[i] = ng[i];
        o.lk[i] = lr[i] && ng[i] != '0;
      end
    end
    o.ptr = any ? 8'((int'(s.ptr) + 1) % n) : s.ptr;
    return o;
  endfunction

  task automatic step();
    st_t ea, eb;
    int bad;
    logic [3:0] g, colacc, held;
    @(negedge clk);
    for (int i = 0; i < 4; i++) ifa.requests_i[i] = ra[i][3:0];
    ifa.lock_req_i = la[3:0];
    ifa.release_i  = rla[3:0];
    for (int i = 0; i < 3; i++) ifb.requests_i[i] = rb[i][4:0];
    ifb.lock_req_i = lb[2:0];
    ifb.release_i  = rlb[2:0];
    pa = sa;
    sa = model(sa, 4, 4, ra, la, rla);
    sb = model(sb, 3, 5, rb, lb, rlb);
    qa.push_back(sa);
    qb.push_back(sb);
    @(posedge clk);
    #1;
    ea = qa.pop_front();
    eb = qb.pop_front();
    for (int i = 0; i < 4; i++) chk($sformatf("a_g%0d", i), 32'(ifa.grants_o[i]), 32'(ea.g[i][3:0]));
    chk("a_locked", 32'(ifa.locked_o), 32'(ea.lk[3:0]));
    chk("a_ptr", 32'(dut_a.ptr_q), 32'(ea.ptr));
    for (int i = 0; i < 3; i++) chk($sformatf("b_g%0d", i), 32'(ifb.grants_o[i]), 32'(eb.g[i][4:0]));
    chk("b_locked", 32'(ifb.locked_o), 32'(eb.lk[2:0]));
    chk("b_ptr", 32'(dut_b.ptr_q), 32'(eb.ptr));
    bad = 0;
    colacc = '0;
    for (int i = 0; i < 4; i++) begin
      g = ifa.grants_o[i];
      held = pa.lk[i] ? pa.g[i][3:0] : 4'h0;
      if (!$onehot0(g)) bad |= 1;
      if ((colacc & g) != 4'h0) bad |= 2;
      colacc |= g;
      if ((g & ~(ra[i][3:0] | held)) != 4'h0) bad |= 4;
      if (pa.lk[i] && !rla[i] && g != pa.g[i][3:0]) bad |= 8;
    end
    chk("a_invariants", 32'(bad), 32'd0);
  endtask

  task automatic clear_inputs();
    ra = '0; rb = '0; la = '0; rla = '0; lb = '0; rlb = '0;
    ifa.requests_i = '0; ifa.lock_req_i = '0; ifa.release_i = '0;
    ifb.requests_i = '0; ifb.lock_req_i = '0; ifb.release_i = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int p;
    clear_inputs();
    sa = '0; sb = '0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_a_grants", 32'(ifa.grants_o), 32'd0);
    chk("rst_a_locked", 32'(ifa.locked_o), 32'd0);
    chk("rst_a_ptr", 32'(dut_a.ptr_q), 32'd0);
    chk("rst_b_grants", 32'(ifb.grants_o), 32'd0);
    // two cycles of dense requests from the pointer-0 diagonal
    ra[0] = 15; ra[1] = 7; ra[2] = 7; ra[3] = 15;
    step();
    chk("t1_e1_grants", 32'(ifa.grants_o), 32'h2401);
    chk("t1_e1_ptr", 32'(dut_a.ptr_q), 32'd1);
    step();
    chk("t1_e2_grants", 32'(ifa.grants_o), 32'h4012);
    chk("t1_e2_ptr", 32'(dut_a.ptr_q), 32'd2);
    // lock column 0 for requester 0, then contend from requester 1
    ra = '0; ra[0] = 1; la = 8'h01;
    step();
    chk("t3_lock_g0", 32'(ifa.grants_o[0]), 32'h1);
    chk("t3_lock_lk", 32'(ifa.locked_o), 32'h1);
    la = '0; ra[0] = 0; ra[1] = 1;
    repeat (5) begin
      step();
      chk("t3_hold_g0", 32'(ifa.grants_o[0]), 32'h1);
      chk("t3_hold_g1", 32'(ifa.grants_o[1]), 32'h0);
    end
    rla = 8'h01;
    step();
    rla = '0;
    chk("t3_rel_g0", 32'(ifa.grants_o[0]), 32'h0);
    chk("t3_rel_g1", 32'(ifa.grants_o[1]), 32'h0);
    chk("t3_rel_lk", 32'(ifa.locked_o), 32'h0);
    step();
    chk("t3_after_g1", 32'(ifa.grants_o[1]), 32'h1);
    // idle cycles keep the pointer; stray release is ignored
    ra = '0;
    p = int'(sa.ptr);
    repeat (3) step();
    chk("t4_idle_grants", 32'(ifa.grants_o), 32'd0);
    chk("t4_idle_ptr", 32'(dut_a.ptr_q), 32'(p));
    rla = 8'h0F;
    step();
    rla = '0;
    chk("t4_stray_rel_lk", 32'(ifa.locked_o), 32'd0);
    chk("t4_stray_rel_ptr", 32'(dut_a.ptr_q), 32'(p));
    // asynchronous reset while a lock is active
    ra[2] = 8; la = 8'h04;
    step();
    chk("t2_pre_lk", 32'(ifa.locked_o), 32'h4);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("t2_async_grants", 32'(ifa.grants_o), 32'd0);
    chk("t2_async_locked", 32'(ifa.locked_o), 32'd0);
    chk("t2_async_ptr", 32'(dut_a.ptr_q), 32'd0);
    clear_inputs();
    sa = '0; sb = '0;
    qa.delete(); qb.delete();
    @(negedge clk);
    reset = 1'b0;
    // rectangular 3x5 with all requests: three grants a cycle, pointer wraps after five
    for (int i = 0; i < 3; i++) rb[i] = 5'h1F;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("t5_count", 32'($countones(ifb.grants_o)), 32'd3);
      chk("t5_ptr", 32'(dut_b.ptr_q), 32'((c + 1) % 5));
    end
    // random traffic with locks and releases on both instances
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < 4; i++) ra[i] = alloc_req_t'($urandom_range(0, 15));
      for (int i = 0; i < 3; i++) rb[i] = alloc_req_t'($urandom_range(0, 31));
      la  = 8'($urandom);
      lb  = 8'($urandom);
      rla = 8'($urandom) & 8'($urandom);
      rlb = 8'($urandom) & 8'($urandom);
      step();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
